// File: rtl/waitxn_pkg.sv
// waitxn_pkg: shared types and helpers for the clocked N-channel exclusive wait element.
//   waitxn_state_t : FSM state encoding (IDLE, GRANT, RELEASE)
//   WAITXN_MAX_N   : largest supported channel count
//   waitxn_idx_w   : width of a channel index, never less than 1
package waitxn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } waitxn_state_t;

    localparam int unsigned WAITXN_MAX_N = 32;

    // Index width for n channels; a 1- or 2-channel element still needs one bit.
    function automatic int unsigned waitxn_idx_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/waitxn_sync_chain.sv
// waitxn_sync_chain: per-bit flop synchroniser of configurable depth.
//   clk   : sampling clock
//   rst_n : synchronous active-low reset, clears every stage to 0
//   d     : asynchronous input vector (W bits)
//   q     : d delayed by DEPTH flops; DEPTH=0 passes d straight through
module waitxn_sync_chain #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        // Input is already synchronous; clock and reset are intentionally unused.
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n};
        assign q = d;
    end else begin : g_flops
        logic [W-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/waitxn_clk.sv
// waitxn_clk: clocked N-channel exclusive wait element.
// While ctrl is high, grants exactly one channel whose synchronised sig is high;
// after ctrl falls, waits for that channel's sig to return low before dropping
// the grant.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   sig   : N asynchronous request lines (synchronised by SYNC_STAGES flops)
//   ctrl  : phase control, synchronous to clk
//   g     : registered one-hot or zero grant vector
//   gid   : index of the granted channel, holds its last value when g=0
//   busy  : high while in GRANT or RELEASE
// Build option: define WAITXN_RR_EN for round-robin selection; the default
// build uses fixed priority with the lowest index winning.
module waitxn_clk
    import waitxn_pkg::*;
#(
    parameter int unsigned N           = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 sig,
    input  logic                         ctrl,
    output logic [N-1:0]                 g,
    output logic [waitxn_idx_w(N)-1:0]   gid,
    output logic                         busy
);

    localparam int unsigned IW = waitxn_idx_w(N);

    if (N < 2 || N > WAITXN_MAX_N) begin : g_bad_n
        $error("waitxn_clk: N out of range");
    end
    if (SYNC_STAGES > 3) begin : g_bad_sync
        $error("waitxn_clk: SYNC_STAGES out of range");
    end

    logic [N-1:0]  sig_s;
    waitxn_state_t state;
    logic [IW-1:0] k;
    logic [IW-1:0] sel_c;
    logic [N-1:0]  onehot_c;

    waitxn_sync_chain #(
        .W     (N),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig),
        .q     (sig_s)
    );

    // Lowest set bit of req; returns 0 when req is empty.
    function automatic logic [IW-1:0] first_set(input logic [N-1:0] req);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
        return idx;
    endfunction

`ifdef WAITXN_RR_EN
    logic [IW-1:0] p;
    logic [IW-1:0] p_next_c;

    // Rotate req so bit p lands at 0, find the first set bit, then undo the rotation mod N.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] start);
        logic [2*N-1:0] dbl;
        logic [IW-1:0]  off;
        logic [IW:0]    sum;
        dbl = {req, req} >> start;
        off = first_set(dbl[N-1:0]);
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        return sum[IW-1:0];
    endfunction

    assign sel_c    = pick(sig_s, p);
    assign p_next_c = (sel_c == IW'(N - 1)) ? '0 : sel_c + IW'(1);
`else
    assign sel_c = first_set(sig_s);
`endif

    assign onehot_c = N'(1) << sel_c;
    assign gid      = k;

    // Grant FSM; g, busy and k (gid) all change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
            busy  <= 1'b0;
            k     <= '0;
`ifdef WAITXN_RR_EN
            p     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl && (|sig_s)) begin
                        k     <= sel_c;
                        g     <= onehot_c;
                        busy  <= 1'b1;
                        state <= GRANT;
`ifdef WAITXN_RR_EN
                        p     <= p_next_c;
`endif
                    end else begin
                        g     <= '0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // A falling sig_s[k] here is only acted on once ctrl is low.
                    if (!ctrl) begin
                        if (!sig_s[k]) begin
                            g     <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // ctrl is ignored until the granted line returns low.
                    if (!sig_s[k]) begin
                        g     <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    g     <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/waitxn_clk.md
# waitxn_clk

Clocked, N-channel generalisation of the two-input exclusive wait element. On a `ctrl` rising phase it waits for any `sig[i]` to go high and grants exactly one channel. On the `ctrl` falling phase it waits for the granted `sig` to return low before withdrawing the grant. It sits between asynchronous request lines and synchronous control logic and replaces the two-channel asynchronous element where a clock is available.

## Interface
Parameters:
- `N`, 2: channel count, 2..32.
- `SYNC_STAGES`, 2: flop stages on each `sig` input, 0..3. 0 means `sig` is already synchronous to `clk`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `sig`  in  N  asynchronous request lines, synchronised internally.
- `ctrl`  in  1  enable/phase control, synchronous to `clk`.
- `g`  out  N  one-hot or zero grant vector, registered.
- `gid`  out  max(1,$clog2(N))  index of the granted channel; holds its last value when `g`=0.
- `busy`  out  1  high in GRANT and RELEASE.

## Operation
- `sig_s` is `sig` after `SYNC_STAGES` flops. All FSM decisions use `sig_s` and `ctrl`.
- FSM states: IDLE, GRANT, RELEASE. Register `k` holds the granted index.
- IDLE:
  - `ctrl`=1 and `sig_s`≠0: pick k, set `g`=onehot(k), `gid`=k, go to GRANT.
  - Otherwise stay; `g`=0.
- GRANT:
  - `ctrl`=1: hold.
  - `ctrl`=0 and `sig_s[k]`=0 in the same cycle: `g`=0, go to IDLE.
  - `ctrl`=0 and `sig_s[k]`=1: go to RELEASE; `g` is held.
- RELEASE:
  - `sig_s[k]`=0: `g`=0, go to IDLE.
  - `ctrl` re-rising here is ignored until IDLE is reached.
- Exclusion: `g` is never more than one bit set. Other channels' `sig` are ignored while `busy`.
- `sig_s[k]` falling while still in GRANT is legal; it is only acted on once `ctrl`=0.
- A `ctrl` pulse with no `sig` high produces no grant and no state change.
- Selection: fixed priority, lowest index wins (see Configuration).
- Reset: state=IDLE, `g`=0, `gid`=0, `busy`=0, `k`=0, sync flops=0, RR pointer=0. Reset asserted mid-grant drops `g` on the next edge regardless of `sig` or `ctrl`.

## Timing
- `sig` pin rising → `g` rising: `SYNC_STAGES`+1 cycles minimum, when `ctrl` is already 1.
- `ctrl` rising with `sig_s` already high → `g` high on the next edge (1 cycle).
- `ctrl` falling → `g` falling:
  - 1 cycle if `sig_s[k]` is already 0.
  - Otherwise 1 cycle after `sig_s[k]` falls (pin-to-`g` = `SYNC_STAGES`+1).
- Minimum IDLE dwell between grants: 1 cycle. Back-to-back grants are spaced by at least 2 cycles.
- `busy` and `gid` update on the same edge as `g`.

## Configuration
- `WAITXN_RR_EN` defined: round-robin selection. A pointer `p` holds the search start. At each grant of index k, `p` is set to (k+1) mod N. The first set `sig_s` bit at or after `p`, wrapping, wins.
- `WAITXN_RR_EN` undefined: fixed priority, lowest index wins. No pointer register is built.

## Structure
- `waitxn_pkg` holds:
  - state enum `waitxn_state_t` {IDLE, GRANT, RELEASE}.
  - `WAITXN_MAX_N`=32 constant.
  - function `waitxn_idx_w(N)` returning max(1,$clog2(N)).
- Sub-module `waitxn_sync_chain`: parametrised-depth per-bit synchroniser. Depth 0 is a pass-through. Reset is synchronous to 0. One instance covers the N-bit vector.
- Selection logic (priority encoder, rotate for RR) stays in `waitxn_clk` as a function.

## Test plan
- N=2, SYNC_STAGES=2: `ctrl`=1; `sig`=01 at cycle 0 → `g`=01, `gid`=0, `busy`=1 at cycle 3. Then `ctrl`=0 with `sig` still 01 → RELEASE, `g` held. Then `sig`=00 → `g`=00 three cycles later.
- N=4: `sig`=1010 simultaneously with `ctrl`=1:
  - Fixed: `gid`=1.
  - RR (`WAITXN_RR_EN`): repeated 4-phase cycles with `sig` held at 1010 give `gid` 1, 3, 1, 3.
- Exclusion: during a grant on channel 0, assert `sig[1]` → `g` stays 01 until release. Re-raising `ctrl` then grants channel 1.
- Same-cycle release: in GRANT, drop `ctrl` and `sig_s[k]` on the same cycle → IDLE and `g`=0 one cycle later, with no RELEASE cycle.
- `ctrl` pulse (1 cycle) with `sig`=0 → `g` stays 0, `busy` stays 0.
- Reset mid-operation: `rst_n`=0 for 1 cycle during RELEASE → next edge `g`=0, `gid`=0, `busy`=0. After `rst_n`=1 with `ctrl`=1 and `sig` high, a new grant follows after `SYNC_STAGES`+1 cycles.
